// File: rtl/dcache_wt.sv
// dcache_wt: direct-mapped, write-through, no-write-allocate L1 data cache
// for the memory stage of a 5-stage RISC-V core.
//
// Ports:
//   clk_i, rst_ni         clock, asynchronous active-low reset
//   mem_read_i            load access this cycle
//   mem_write_i           store access this cycle (wins over mem_read_i)
//   type_control_i        00 byte, 01 half, 10/11 word
//   sign_ext_flag_i       1 = sign-extend sub-word loads
//   addr_i                byte address
//   write_data_i          right-aligned store data
//   read_data_o           extended load result (0 unless a read hit)
//   cache_stall_o         1 = hold pipeline, access not complete
//   bm_req_o .. bm_wstrb_o  registered backing-memory request
//   bm_rdata_i, bm_ack_i  backing-memory response
module dcache_wt #(
  parameter int unsigned DATA_WIDTH        = 32,
  parameter int unsigned INDEX_BITS        = 4,
  parameter int unsigned OFFSET_WORDS_BITS = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  mem_read_i,
  input  logic                  mem_write_i,
  input  logic [1:0]            type_control_i,
  input  logic                  sign_ext_flag_i,
  input  logic [DATA_WIDTH-1:0] addr_i,
  input  logic [DATA_WIDTH-1:0] write_data_i,
  output logic [DATA_WIDTH-1:0] read_data_o,
  output logic                  cache_stall_o,
  output logic                  bm_req_o,
  output logic                  bm_we_o,
  output logic [DATA_WIDTH-1:0] bm_addr_o,
  output logic [DATA_WIDTH-1:0] bm_wdata_o,
  output logic [3:0]            bm_wstrb_o,
  input  logic [DATA_WIDTH-1:0] bm_rdata_i,
  input  logic                  bm_ack_i
);

  localparam int unsigned IdxLsb  = 2 + OFFSET_WORDS_BITS;
  localparam int unsigned TagLsb  = IdxLsb + INDEX_BITS;
  localparam int unsigned TagBits = DATA_WIDTH - TagLsb;
  localparam int unsigned Sets    = 1 << INDEX_BITS;
  localparam int unsigned Words   = 1 << OFFSET_WORDS_BITS;

  typedef enum logic [1:0] {StIdle, StFill, StWrite} state_e;

  state_e                       state_q, state_d;
  logic [OFFSET_WORDS_BITS-1:0] cnt_q, cnt_d;
  logic                         req_q, req_d;
  logic                         we_q, we_d;
  logic [DATA_WIDTH-1:0]        baddr_q, baddr_d;
  logic [DATA_WIDTH-1:0]        wdata_q, wdata_d;
  logic [3:0]                   wstrb_q, wstrb_d;
  logic [Sets-1:0]              valid_q;

  logic [TagBits-1:0]    tag_q  [Sets];
  logic [DATA_WIDTH-1:0] data_q [Sets][Words];

  // Request side (pipeline address)
  logic [INDEX_BITS-1:0]        idx;
  logic [OFFSET_WORDS_BITS-1:0] word;
  logic [TagBits-1:0]           tag;
  logic                         hit;
  logic [DATA_WIDTH-1:0]        rd_word;

  assign idx     = addr_i[TagLsb-1:IdxLsb];
  assign word    = addr_i[IdxLsb-1:2];
  assign tag     = addr_i[DATA_WIDTH-1:TagLsb];
  assign hit     = valid_q[idx] && (tag_q[idx] == tag);
  assign rd_word = data_q[idx][word];

  // Backing side: fill/merge use the held request address, not the pipeline one
  logic [INDEX_BITS-1:0]        b_idx;
  logic [OFFSET_WORDS_BITS-1:0] b_word;
  logic [TagBits-1:0]           b_tag;
  logic                         b_hit;
  logic                         ack;

  assign b_idx  = baddr_q[TagLsb-1:IdxLsb];
  assign b_word = baddr_q[IdxLsb-1:2];
  assign b_tag  = baddr_q[DATA_WIDTH-1:TagLsb];
  assign b_hit  = valid_q[b_idx] && (tag_q[b_idx] == b_tag);
  assign ack    = bm_ack_i && req_q;

  // Load lane select and extension
  logic [7:0]            ld_byte;
  logic [15:0]           ld_half;
  logic [DATA_WIDTH-1:0] ld_ext;

  always_comb begin
    unique case (addr_i[1:0])
      2'b00:   ld_byte = rd_word[7:0];
      2'b01:   ld_byte = rd_word[15:8];
      2'b10:   ld_byte = rd_word[23:16];
      default: ld_byte = rd_word[31:24];
    endcase
    ld_half = addr_i[1] ? rd_word[31:16] : rd_word[15:0];
    case (type_control_i)
      2'b00:   ld_ext = {{24{sign_ext_flag_i & ld_byte[7]}}, ld_byte};
      2'b01:   ld_ext = {{16{sign_ext_flag_i & ld_half[15]}}, ld_half};
      default: ld_ext = rd_word;
    endcase
  end

  assign read_data_o = (state_q == StIdle && mem_read_i && !mem_write_i && hit) ? ld_ext : '0;

  // Store lane replication and byte enables
  logic [DATA_WIDTH-1:0] st_data;
  logic [3:0]            st_strb;

  always_comb begin
    case (type_control_i)
      2'b00: begin
        st_data = {4{write_data_i[7:0]}};
        st_strb = 4'b0001 << addr_i[1:0];
      end
      2'b01: begin
        st_data = {2{write_data_i[15:0]}};
        st_strb = 4'b0011 << {addr_i[1], 1'b0};
      end
      default: begin
        st_data = write_data_i;
        st_strb = 4'b1111;
      end
    endcase
  end

  logic fill_we, fill_done, wr_merge, valid_clr;

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    req_d         = req_q;
    we_d          = we_q;
    baddr_d       = baddr_q;
    wdata_d       = wdata_q;
    wstrb_d       = wstrb_q;
    cache_stall_o = 1'b0;
    fill_we       = 1'b0;
    fill_done     = 1'b0;
    wr_merge      = 1'b0;
    valid_clr     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (mem_write_i) begin
          cache_stall_o = 1'b1;
          state_d       = StWrite;
          req_d         = 1'b1;
          we_d          = 1'b1;
          baddr_d       = {addr_i[DATA_WIDTH-1:2], 2'b00};
          wdata_d       = st_data;
          wstrb_d       = st_strb;
        end else if (mem_read_i && !hit) begin
          cache_stall_o = 1'b1;
          state_d       = StFill;
          cnt_d         = '0;
          req_d         = 1'b1;
          we_d          = 1'b0;
          baddr_d       = {addr_i[DATA_WIDTH-1:IdxLsb], {IdxLsb{1'b0}}};
          // Line is overwritten word by word; keep it invalid until complete
          valid_clr     = 1'b1;
        end
      end
      StFill: begin
        cache_stall_o = 1'b1;
        if (ack) begin
          fill_we = 1'b1;
          cnt_d   = cnt_q + 1'b1;
          baddr_d = baddr_q + DATA_WIDTH'(4);
          if (cnt_q == {OFFSET_WORDS_BITS{1'b1}}) begin
            fill_done = 1'b1;
            req_d     = 1'b0;
            state_d   = StIdle;
          end
        end
      end
      StWrite: begin
        cache_stall_o = !bm_ack_i;
        if (ack) begin
          wr_merge = b_hit;
          req_d    = 1'b0;
          we_d     = 1'b0;
          state_d  = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      baddr_q <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      valid_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      we_q    <= we_d;
      baddr_q <= baddr_d;
      wdata_q <= wdata_d;
      wstrb_q <= wstrb_d;
      if (valid_clr) valid_q[idx] <= 1'b0;
      if (fill_done) valid_q[b_idx] <= 1'b1;
    end
  end

  // Tag and data arrays carry no reset; valid bits gate their use
  always_ff @(posedge clk_i) begin
    if (fill_we) data_q[b_idx][cnt_q] <= bm_rdata_i;
    if (fill_done) tag_q[b_idx] <= b_tag;
    if (wr_merge) begin
      for (int b = 0; b < 4; b++) begin
        if (wstrb_q[b]) data_q[b_idx][b_word][8*b +: 8] <= wdata_q[8*b +: 8];
      end
    end
  end

  assign bm_req_o   = req_q;
  assign bm_we_o    = we_q;
  assign bm_addr_o  = baddr_q;
  assign bm_wdata_o = wdata_q;
  assign bm_wstrb_o = wstrb_q;

endmodule

// File: tb/tb_dcache_wt.sv
// Directed testbench for dcache_wt with a 2-cycle-latency backing memory model.
module tb_dcache_wt;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        mem_read = 1'b0;
  logic        mem_write = 1'b0;
  logic [1:0]  type_control = 2'b10;
  logic        sign_ext = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] write_data = '0;
  logic [31:0] read_data;
  logic        cache_stall;
  logic        bm_req;
  logic        bm_we;
  logic [31:0] bm_addr;
  logic [31:0] bm_wdata;
  logic [3:0]  bm_wstrb;
  logic [31:0] bm_rdata = '0;
  logic        bm_ack = 1'b0;

  int errs = 0;
  int checks = 0;
  int rd_cnt = 0;
  int wr_cnt = 0;
  int wcnt = 0;

  logic [31:0] mem [0:2047];

  always #5 clk = ~clk;

  dcache_wt dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .mem_read_i     (mem_read),
    .mem_write_i    (mem_write),
    .type_control_i (type_control),
    .sign_ext_flag_i(sign_ext),
    .addr_i         (addr),
    .write_data_i   (write_data),
    .read_data_o    (read_data),
    .cache_stall_o  (cache_stall),
    .bm_req_o       (bm_req),
    .bm_we_o        (bm_we),
    .bm_addr_o      (bm_addr),
    .bm_wdata_o     (bm_wdata),
    .bm_wstrb_o     (bm_wstrb),
    .bm_rdata_i     (bm_rdata),
    .bm_ack_i       (bm_ack)
  );

  // Backing memory: ack on the second cycle of each request word
  always @(negedge clk) begin
    if (bm_req && wcnt == 1) begin
      bm_ack = 1'b1;
      wcnt = 0;
      if (bm_we) begin
        wr_cnt++;
        for (int b = 0; b < 4; b++) begin
          if (bm_wstrb[b]) mem[bm_addr[12:2]][8*b +: 8] = bm_wdata[8*b +: 8];
        end
      end else begin
        rd_cnt++;
        bm_rdata = mem[bm_addr[12:2]];
      end
    end else begin
      bm_ack = 1'b0;
      bm_rdata = '0;
      wcnt = bm_req ? wcnt + 1 : 0;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // Presents one access and holds it until cache_stall drops.
  task automatic do_access(input logic rd, input logic wr, input logic [1:0] ty,
                           input logic sx, input logic [31:0] a, input logic [31:0] wd,
                           output int stalls, output logic [31:0] rdat,
                           output logic [3:0] strb_seen, output logic [31:0] wdat_seen);
    logic done;
    mem_read = rd;
    mem_write = wr;
    type_control = ty;
    sign_ext = sx;
    addr = a;
    write_data = wd;
    stalls = 0;
    rdat = '0;
    strb_seen = '0;
    wdat_seen = '0;
    done = 1'b0;
    for (int i = 0; i < 60 && !done; i++) begin
      @(negedge clk);
      #1;
      if (bm_req && bm_we) begin
        strb_seen = bm_wstrb;
        wdat_seen = bm_wdata;
      end
      if (!cache_stall) begin
        done = 1'b1;
        rdat = read_data;
      end else begin
        stalls++;
      end
    end
    checks++;
    if (!done) begin
      errs++;
      $display("FAIL access_timeout addr=%h: stall still high after 60 cycles", a);
    end
    @(posedge clk);
    #1;
    mem_read = 1'b0;
    mem_write = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (bm_req !== 1'b0) begin errs++; $display("FAIL rst_req got=%b want=0", bm_req); end
    checks++;
    if (bm_we !== 1'b0) begin errs++; $display("FAIL rst_we got=%b want=0", bm_we); end
    checks++;
    if (cache_stall !== 1'b0) begin
      errs++; $display("FAIL rst_stall got=%b want=0", cache_stall);
    end
    checks++;
    if (read_data !== 32'h0) begin
      errs++; $display("FAIL rst_rdata got=%h want=0", read_data);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_cold_miss();
    int st, r0;
    logic [31:0] rd, wdt;
    logic [3:0] sb;
    r0 = rd_cnt;
    do_access(1, 0, 2'b10, 0, 32'h104, 0, st, rd, sb, wdt);
    checks++;
    if (st !== 9) begin errs++; $display("FAIL miss_stall got=%0d want=9", st); end
    checks++;
    if (rd !== 32'hA1) begin errs++; $display("FAIL miss_data got=%h want=000000a1", rd); end
    checks++;
    if (rd_cnt - r0 !== 4) begin
      errs++; $display("FAIL miss_reads got=%0d want=4", rd_cnt - r0);
    end
    r0 = rd_cnt;
    do_access(1, 0, 2'b10, 0, 32'h10C, 0, st, rd, sb, wdt);
    checks++;
    if (st !== 0) begin errs++; $display("FAIL hit_stall got=%0d want=0", st); end
    checks++;
    if (rd !== 32'hA3) begin errs++; $display("FAIL hit_data got=%h want=000000a3", rd); end
    checks++;
    if (rd_cnt - r0 !== 0) begin
      errs++; $display("FAIL hit_reads got=%0d want=0", rd_cnt - r0);
    end
  endtask

  task automatic test_subword();
    int st;
    logic [31:0] rd, wdt;
    logic [3:0] sb;
    logic [1:0]  ty_t [4] = '{2'b00, 2'b00, 2'b01, 2'b01};
    logic        sx_t [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    logic [31:0] ex_t [4] = '{32'hFFFFFFFF, 32'h000000FF, 32'hFFFF80FF, 32'h000080FF};
    do_access(1, 0, 2'b10, 0, 32'h200, 0, st, rd, sb, wdt);
    checks++;
    if (rd !== 32'h80FF7F01) begin
      errs++; $display("FAIL sub_fill got=%h want=80ff7f01", rd);
    end
    for (int i = 0; i < 4; i++) begin
      do_access(1, 0, ty_t[i], sx_t[i], 32'h202, 0, st, rd, sb, wdt);
      checks++;
      if (rd !== ex_t[i] || st !== 0) begin
        errs++;
        $display("FAIL subword_%0d got=%h stall=%0d want=%h stall=0", i, rd, st, ex_t[i]);
      end
    end
  endtask

  task automatic test_store_hit();
    int st, r0, w0;
    logic [31:0] rd, wdt;
    logic [3:0] sb;
    r0 = rd_cnt;
    w0 = wr_cnt;
    do_access(0, 1, 2'b00, 0, 32'h201, 32'hFFFFFF5A, st, rd, sb, wdt);
    checks++;
    if (sb !== 4'b0010) begin errs++; $display("FAIL sb_strb got=%b want=0010", sb); end
    checks++;
    if (wdt !== 32'h5A5A5A5A) begin
      errs++; $display("FAIL sb_wdata got=%h want=5a5a5a5a", wdt);
    end
    checks++;
    if (st !== 2) begin errs++; $display("FAIL sb_stall got=%0d want=2", st); end
    checks++;
    if (wr_cnt - w0 !== 1) begin
      errs++; $display("FAIL sb_writes got=%0d want=1", wr_cnt - w0);
    end
    do_access(1, 0, 2'b10, 0, 32'h200, 0, st, rd, sb, wdt);
    checks++;
    if (rd !== 32'h80FF5A01 || st !== 0) begin
      errs++; $display("FAIL sb_merge got=%h stall=%0d want=80ff5a01 stall=0", rd, st);
    end
    do_access(0, 1, 2'b01, 0, 32'h206, 32'h1234BEEF, st, rd, sb, wdt);
    checks++;
    if (sb !== 4'b1100 || wdt !== 32'hBEEFBEEF) begin
      errs++; $display("FAIL sh_req got strb=%b data=%h want strb=1100 data=beefbeef", sb, wdt);
    end
    do_access(1, 0, 2'b10, 0, 32'h204, 0, st, rd, sb, wdt);
    checks++;
    if (rd !== 32'hBEEF0081 || st !== 0) begin
      errs++; $display("FAIL sh_merge got=%h stall=%0d want=beef0081 stall=0", rd, st);
    end
    checks++;
    if (rd_cnt - r0 !== 0) begin
      errs++; $display("FAIL store_hit_reads got=%0d want=0", rd_cnt - r0);
    end
  endtask

  task automatic test_store_miss();
    int st, r0, w0;
    logic [31:0] rd, wdt;
    logic [3:0] sb;
    r0 = rd_cnt;
    w0 = wr_cnt;
    do_access(0, 1, 2'b10, 0, 32'h300, 32'h12345678, st, rd, sb, wdt);
    checks++;
    if (wr_cnt - w0 !== 1 || rd_cnt - r0 !== 0) begin
      errs++;
      $display("FAIL sw_miss_traffic got wr=%0d rd=%0d want wr=1 rd=0", wr_cnt - w0, rd_cnt - r0);
    end
    checks++;
    if (sb !== 4'b1111 || wdt !== 32'h12345678) begin
      errs++; $display("FAIL sw_req got strb=%b data=%h want strb=1111 data=12345678", sb, wdt);
    end
    r0 = rd_cnt;
    do_access(1, 0, 2'b10, 0, 32'h300, 0, st, rd, sb, wdt);
    checks++;
    if (rd_cnt - r0 !== 4 || st !== 9) begin
      errs++;
      $display("FAIL ld_after_sw got rd=%0d stall=%0d want rd=4 stall=9", rd_cnt - r0, st);
    end
    checks++;
    if (rd !== 32'h12345678) begin
      errs++; $display("FAIL ld_after_sw_data got=%h want=12345678", rd);
    end
  endtask

  task automatic test_conflict();
    int st, r0;
    logic [31:0] rd, wdt;
    logic [3:0] sb;
    logic [31:0] a_t  [4] = '{32'h1100, 32'h100, 32'h1100, 32'h100};
    logic [31:0] ex_t [4] = '{32'hC0000440, 32'hA0, 32'hC0000440, 32'hA0};
    for (int i = 0; i < 4; i++) begin
      r0 = rd_cnt;
      do_access(1, 0, 2'b10, 0, a_t[i], 0, st, rd, sb, wdt);
      checks++;
      if (rd_cnt - r0 !== 4 || rd !== ex_t[i]) begin
        errs++;
        $display("FAIL conflict_%0d got rd=%0d data=%h want rd=4 data=%h",
                 i, rd_cnt - r0, rd, ex_t[i]);
      end
    end
  endtask

  task automatic test_reset_mid_fill();
    int st, r0;
    logic [31:0] rd, wdt;
    logic [3:0] sb;
    logic seen;
    r0 = rd_cnt;
    seen = 1'b0;
    mem_read = 1'b1;
    mem_write = 1'b0;
    type_control = 2'b10;
    addr = 32'h400;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      #1;
      if (rd_cnt - r0 == 2) seen = 1'b1;
    end
    checks++;
    if (!seen) begin errs++; $display("FAIL midfill_timeout got acks=%0d want=2", rd_cnt - r0); end
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if (bm_req !== 1'b0) begin errs++; $display("FAIL midfill_req got=%b want=0", bm_req); end
    mem_read = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    r0 = rd_cnt;
    do_access(1, 0, 2'b10, 0, 32'h400, 0, st, rd, sb, wdt);
    checks++;
    if (rd_cnt - r0 !== 4 || st !== 9) begin
      errs++;
      $display("FAIL refill got rd=%0d stall=%0d want rd=4 stall=9", rd_cnt - r0, st);
    end
    checks++;
    if (rd !== 32'hC0000100) begin errs++; $display("FAIL refill_data got=%h want=c0000100", rd); end
  endtask

  initial begin
    for (int i = 0; i < 2048; i++) mem[i] = 32'hC000_0000 | i;
    for (int k = 0; k < 4; k++) mem[16'h40 + k] = 32'hA0 + k;
    mem[16'h80] = 32'h80FF7F01;
    test_reset();
    test_cold_miss();
    test_subword();
    test_store_hit();
    test_store_miss();
    test_conflict();
    test_reset_mid_fill();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
